maze_bank_scheduler: RTL

//  Sequences tile redraws into the two-bank (ping-pong) maze RAM scanned by the graphics address path.

---
 rtl/maze_bank_if.sv | 27 ++
 rtl/maze_bank_scheduler.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/maze_bank_if.sv
// rtl/maze_bank_if.sv - tile request, tile ROM and maze RAM write bus of the bank scheduler
interface maze_bank_if #(
  parameter int TILE_ID_W = 5
);
  logic                   req_valid;
  logic [4:0]             req_tile_x;
  logic [5:0]             req_tile_y;
  logic [TILE_ID_W-1:0]   req_tile_id;
  logic                   req_ready;
  logic                   req_drop;
  logic [TILE_ID_W+5:0]   rom_addr;
  logic [7:0]             rom_data;
  logic                   wr_en;
  logic                   wr_bank;
  logic [15:0]            wr_addr;
  logic [7:0]             wr_data;

  modport master (
    output req_valid, req_tile_x, req_tile_y, req_tile_id, rom_data,
    input  req_ready, req_drop, rom_addr, wr_en, wr_bank, wr_addr, wr_data
  );

  modport slave (
    input  req_valid, req_tile_x, req_tile_y, req_tile_id, rom_data,
    output req_ready, req_drop, rom_addr, wr_en, wr_bank, wr_addr, wr_data
  );
endinterface

// File: rtl/maze_bank_scheduler.sv
// rtl/maze_bank_scheduler.sv - ping-pong maze RAM tile redraw scheduler with vblank bank swap and replay
// Optional FB_CLEAR_EN: zero both banks after reset before accepting requests.
module maze_bank_scheduler #(
  parameter int TILE_ID_W    = 5,
  parameter int REPLAY_DEPTH = 8,
  parameter int XTILES       = 30,
  parameter int YTILES       = 33,
  parameter int ROW_PITCH    = 264
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] vc,
  maze_bank_if.slave bus,
  output logic       disp_bank,
  output logic       busy
);
  localparam int PTR_W = $clog2(REPLAY_DEPTH);
  localparam int ENT_W = 11 + TILE_ID_W;
  localparam logic [PTR_W:0] PTR_ONE = 1;

  typedef enum logic [1:0] {IDLE, DRAW, REPLAY, CLEAR} state_t;

`ifdef FB_CLEAR_EN
  localparam state_t RESET_STATE = CLEAR;
  localparam logic [15:0] CLR_LAST = 16'(XTILES * 8 * ROW_PITCH - 1);
  logic        clr_bank;
  logic [15:0] clr_addr;
  logic        clr_last;
  assign clr_last = clr_bank && (clr_addr == CLR_LAST);
`else
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t state, state_nx;

  logic [ENT_W-1:0]     fifo_mem [REPLAY_DEPTH];
  logic [PTR_W:0]       wr_ptr, rd_ptr, rd_ptr_nx;
  logic [ENT_W-1:0]     head, next_head;
  logic                 fifo_full;
  logic                 pending, vblank, vblank_d, vblank_edge, swap_now;
  logic                 accept, in_range, tile_last, push, pop, drawing;
  logic [4:0]           cur_x;
  logic [5:0]           cur_y;
  logic [TILE_ID_W-1:0] cur_id;
  logic [5:0]           pix;
  logic [7:0]           col;
  logic [8:0]           row;
  logic [15:0]          pix_addr;
  logic                 s1_valid, s1_bank;
  logic [15:0]          s1_addr;

  // Column-major RAM: each xpos line is ROW_PITCH words of ypos.
  assign col      = {cur_x, pix[2:0]};
  assign row      = {cur_y, pix[5:3]};
  assign pix_addr = 16'(32'(col) * ROW_PITCH) + 16'(row);

  assign rd_ptr_nx = rd_ptr + PTR_ONE;
  assign head      = fifo_mem[rd_ptr[PTR_W-1:0]];
  assign next_head = fifo_mem[rd_ptr_nx[PTR_W-1:0]];

  always_comb begin
    state_nx    = state;
    vblank      = (vc >= 10'd480);
    vblank_edge = vblank & ~vblank_d;
    fifo_full   = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                  (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    swap_now    = vblank_edge && (state == IDLE) && pending;
    bus.req_ready = (state == IDLE) && !fifo_full && !swap_now && rst;
    accept      = bus.req_valid && bus.req_ready;
    in_range    = ({1'b0, bus.req_tile_x} < 6'(XTILES)) &&
                  ({1'b0, bus.req_tile_y} < 7'(YTILES));
    drawing     = (state == DRAW) || (state == REPLAY);
    tile_last   = (pix == 6'd63);
    push        = (state == DRAW) && tile_last;
    pop         = (state == REPLAY) && tile_last;
    busy        = (state != IDLE);
    bus.rom_addr = drawing ? {cur_id, pix[2:0], pix[5:3]} : '0;
    case (state)
      IDLE: begin
        if (swap_now)                 state_nx = REPLAY;
        else if (accept && in_range)  state_nx = DRAW;
      end
      DRAW:   if (tile_last) state_nx = IDLE;
      REPLAY: if (tile_last && (rd_ptr_nx == wr_ptr)) state_nx = IDLE;
`ifdef FB_CLEAR_EN
      CLEAR:  if (clr_last) state_nx = IDLE;
`endif
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= RESET_STATE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst && push) fifo_mem[wr_ptr[PTR_W-1:0]] <= {cur_x, cur_y, cur_id};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      pending     <= 1'b0;
      vblank_d    <= 1'b0;
      disp_bank   <= 1'b0;
      cur_x       <= '0;
      cur_y       <= '0;
      cur_id      <= '0;
      pix         <= '0;
      s1_valid    <= 1'b0;
      s1_bank     <= 1'b0;
      s1_addr     <= '0;
      bus.wr_en   <= 1'b0;
      bus.wr_bank <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      bus.req_drop <= 1'b0;
`ifdef FB_CLEAR_EN
      clr_bank    <= 1'b0;
      clr_addr    <= '0;
`endif
    end else begin
      vblank_d     <= vblank;
      bus.req_drop <= accept && !in_range;

      // Bank is captured per pixel so a swap right after a tile cannot retarget its tail writes.
      s1_valid    <= drawing;
      s1_bank     <= ~disp_bank;
      s1_addr     <= pix_addr;
      bus.wr_en   <= s1_valid;
      bus.wr_bank <= s1_bank;
      bus.wr_addr <= s1_addr;
      bus.wr_data <= bus.rom_data;

      if (drawing) pix <= pix + 6'd1;

      if (accept && in_range) begin
        cur_x  <= bus.req_tile_x;
        cur_y  <= bus.req_tile_y;
        cur_id <= bus.req_tile_id;
        pix    <= '0;
      end

      if (swap_now) begin
        disp_bank <= ~disp_bank;
        {cur_x, cur_y, cur_id} <= head;
        pix <= '0;
      end

      if (push) begin
        wr_ptr  <= wr_ptr + PTR_ONE;
        pending <= 1'b1;
      end

      if (pop) begin
        rd_ptr <= rd_ptr_nx;
        {cur_x, cur_y, cur_id} <= next_head;
        if (rd_ptr_nx == wr_ptr) pending <= 1'b0;
      end

`ifdef FB_CLEAR_EN
      if (state == CLEAR) begin
        bus.wr_en   <= 1'b1;
        bus.wr_bank <= clr_bank;
        bus.wr_addr <= clr_addr;
        bus.wr_data <= '0;
        if (clr_addr == CLR_LAST) begin
          clr_addr <= '0;
          clr_bank <= 1'b1;
        end else begin
          clr_addr <= clr_addr + 16'd1;
        end
      end
`endif
    end
  end
endmodule
